// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: geometry defaults, state encoding, silent note.
package note_seq_pkg;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOTE_SILENT = 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REC      = 3'd1,
        ST_REC_WR   = 3'd2,
        ST_PLAY     = 3'd3,
        ST_PLAY_RD  = 3'd4,
        ST_PLAY_OUT = 3'd5
    } seq_state_t;

endpackage

// File: rtl/seq_addr_counter.sv
// RAM address counter: clear, increment, terminal-count compare against a length limit, wrap.
module seq_addr_counter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W:0]   limit,
    output logic [ADDR_W-1:0] count,
    output logic              at_last
);

    localparam logic [ADDR_W:0]   LIM_ONE = 1;
    localparam logic [ADDR_W-1:0] STEP    = 1;

    // at_last marks the final word of a sequence of 'limit' words starting at 0
    always_comb at_last = ({1'b0, count} == (limit - LIM_ONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= at_last ? '0 : count + STEP;
    end

endmodule

// File: rtl/note_seq_controller.sv
// Record/playback sequencer owning the single port of the note RAM, one word per tempo tick.
module note_seq_controller
    import note_seq_pkg::*;
#(
    parameter int ADDR_W = note_seq_pkg::ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int DATA_W = note_seq_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              tick,
    input  logic [DATA_W-1:0] note_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] note_out,
    output logic              note_valid,
    output logic              busy,
    output logic [ADDR_W:0]   rec_len,
    output logic              overflow,
    output logic [2:0]        state_out
);

    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE  = 1;
    localparam logic [ADDR_W:0] LEN_ZERO = 0;

    seq_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic              at_last;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [ADDR_W:0]   cnt_limit;

    always_comb begin
        cnt_clr   = (state == ST_IDLE) &&
                    (rec_start || (play_start && (rec_len != LEN_ZERO)));
        cnt_inc   = !stop && ((state == ST_REC_WR) || (state == ST_PLAY_OUT));
        cnt_limit = (state == ST_PLAY_OUT) ? rec_len : FULL_LEN;
    end

    seq_addr_counter #(.ADDR_W(ADDR_W)) u_addr_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .limit   (cnt_limit),
        .count   (addr),
        .at_last (at_last)
    );

    assign ram_addr  = addr;
    assign state_out = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ram_wdata  <= '0;
            ram_wren   <= 1'b0;
            note_out   <= NOTE_SILENT;
            note_valid <= 1'b0;
            busy       <= 1'b0;
            rec_len    <= '0;
            overflow   <= 1'b0;
        end else begin
            ram_wren   <= 1'b0;
            note_valid <= 1'b0;
            if ((state != ST_IDLE) && stop) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                note_out <= NOTE_SILENT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // the last played note is shown for one cycle before going silent
                        note_out <= NOTE_SILENT;
                        if (rec_start) begin
                            state    <= ST_REC;
                            busy     <= 1'b1;
                            rec_len  <= '0;
                            overflow <= 1'b0;
                        end else if (play_start && (rec_len != LEN_ZERO)) begin
                            state <= ST_PLAY;
                            busy  <= 1'b1;
                        end
                    end
                    ST_REC: begin
                        if (tick) begin
                            ram_wdata <= note_in;
                            ram_wren  <= 1'b1;
                            state     <= ST_REC_WR;
                        end
                    end
                    ST_REC_WR: begin
                        rec_len <= {1'b0, addr} + LEN_ONE;
                        if (at_last) begin
                            overflow <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            state <= ST_REC;
                        end
                    end
                    ST_PLAY: begin
                        if (tick)
                            state <= ST_PLAY_RD;
                    end
                    ST_PLAY_RD: state <= ST_PLAY_OUT;
                    ST_PLAY_OUT: begin
                        note_out   <= ram_rdata;
                        note_valid <= 1'b1;
                        if (at_last && !loop_en) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_PLAY;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_seq_controller.sv
// Directed bench for note_seq_controller with a synchronous-read 64x32 RAM model attached.
module tb_note_seq_controller;

    logic        clk;
    logic        reset;
    logic        rec_start;
    logic        play_start;
    logic        stop;
    logic        loop_en;
    logic        tick;
    logic [31:0] note_in;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_rdata;
    logic [31:0] note_out;
    logic        note_valid;
    logic        busy;
    logic [6:0]  rec_len;
    logic        overflow;
    logic [2:0]  state_out;

    logic [31:0] mem [64];
    int          wr_cnt;
    int          n_checks;
    int          n_errors;

    note_seq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .loop_en    (loop_en),
        .tick       (tick),
        .note_in    (note_in),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_rdata  (ram_rdata),
        .note_out   (note_out),
        .note_valid (note_valid),
        .busy       (busy),
        .rec_len    (rec_len),
        .overflow   (overflow),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rec_tick(input logic [31:0] w, input int idx);
        note_in = w;
        tick    = 1'b1;
        cyc(1);
        tick    = 1'b0;
        check($sformatf("wren[%0d]", idx), 32'(ram_wren), 1);
        check($sformatf("waddr[%0d]", idx), 32'(ram_addr), 32'(idx % 64));
        check($sformatf("wdata[%0d]", idx), ram_wdata, w);
        cyc(1);
        check($sformatf("wren_off[%0d]", idx), 32'(ram_wren), 0);
        check($sformatf("rec_len[%0d]", idx), 32'(rec_len), 32'(idx + 1));
    endtask

    task automatic play_tick(input logic [31:0] exp, input string tag);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check({tag, "_st_rd"}, 32'(state_out), 4);
        cyc(1);
        check({tag, "_vld_early"}, 32'(note_valid), 0);
        cyc(1);
        check({tag, "_vld"}, 32'(note_valid), 1);
        check({tag, "_note"}, note_out, exp);
    endtask

    task automatic pulse_rec;
        rec_start = 1'b1;
        cyc(1);
        rec_start = 1'b0;
    endtask

    task automatic pulse_play;
        play_start = 1'b1;
        cyc(1);
        play_start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    logic [31:0] words [3];
    logic [31:0] loop_seq [5];
    int          wr_base;

    initial begin
        n_checks = 0;
        n_errors = 0;
        wr_cnt   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        words[0] = 32'h1; words[1] = 32'h40; words[2] = 32'h1000;
        loop_seq[0] = 32'h1; loop_seq[1] = 32'h40; loop_seq[2] = 32'h1000;
        loop_seq[3] = 32'h1; loop_seq[4] = 32'h40;
        reset = 1'b1; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
        loop_en = 1'b0; tick = 1'b0; note_in = 32'd0;
        cyc(2);

        check("rst_state", 32'(state_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wren", 32'(ram_wren), 0);
        check("rst_rec_len", 32'(rec_len), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_note", note_out, 0);
        check("rst_valid", 32'(note_valid), 0);
        check("rst_addr", 32'(ram_addr), 0);
        reset = 1'b0;
        cyc(1);

        // reset in the middle of a write cycle
        pulse_rec;
        check("t1_state_rec", 32'(state_out), 1);
        check("t1_busy", 32'(busy), 1);
        note_in = 32'hABCD;
        tick    = 1'b1;
        cyc(1);
        tick    = 1'b0;
        check("t1_wren_before", 32'(ram_wren), 1);
        check("t1_state_wr", 32'(state_out), 2);
        reset = 1'b1;
        #2;
        check("t1_wren_rst", 32'(ram_wren), 0);
        check("t1_state_rst", 32'(state_out), 0);
        check("t1_rec_len", 32'(rec_len), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1);
        check("t1_no_write", 32'(wr_cnt), 0);

        // play with nothing recorded is ignored
        pulse_play;
        check("t6_empty_state", 32'(state_out), 0);
        check("t6_empty_busy", 32'(busy), 0);

        // record three notes then stop
        pulse_rec;
        for (int i = 0; i < 3; i++) begin
            cyc(3);
            rec_tick(words[i], i);
        end
        pulse_stop;
        check("t2_state", 32'(state_out), 0);
        check("t2_busy", 32'(busy), 0);
        check("t2_rec_len", 32'(rec_len), 3);
        check("t2_wr_cnt", 32'(wr_cnt), 3);
        for (int i = 0; i < 3; i++) check($sformatf("t2_mem[%0d]", i), mem[i], words[i]);

        // playback without loop: three notes then idle, fourth tick ignored
        loop_en = 1'b0;
        pulse_play;
        check("t3_state_play", 32'(state_out), 3);
        for (int k = 0; k < 3; k++) begin
            cyc(3);
            play_tick(words[k], $sformatf("t3_%0d", k));
            check($sformatf("t3_state_%0d", k), 32'(state_out), (k == 2) ? 0 : 3);
        end
        cyc(1);
        check("t3_note_clear", note_out, 0);
        check("t3_valid_off", 32'(note_valid), 0);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
        check("t3_tick4_valid", 32'(note_valid), 0);
        check("t3_tick4_state", 32'(state_out), 0);
        check("t3_tick4_note", note_out, 0);

        // playback with loop
        loop_en = 1'b1;
        pulse_play;
        for (int k = 0; k < 5; k++) begin
            cyc(3);
            play_tick(loop_seq[k], $sformatf("t4_%0d", k));
        end
        check("t4_state_play", 32'(state_out), 3);
        cyc(2);
        check("t4_note_hold", note_out, 32'h40);
        pulse_stop;
        check("t4_stop_state", 32'(state_out), 0);
        check("t4_stop_note", note_out, 0);
        loop_en = 1'b0;

        // record past the end of the RAM
        pulse_rec;
        wr_base = wr_cnt;
        for (int i = 0; i < 64; i++) begin
            cyc(2);
            rec_tick(32'h100 + 32'(i), i);
        end
        check("t5_overflow", 32'(overflow), 1);
        check("t5_state", 32'(state_out), 0);
        check("t5_busy", 32'(busy), 0);
        cyc(2);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check("t5_tick65_wren", 32'(ram_wren), 0);
        cyc(2);
        check("t5_writes", 32'(wr_cnt - wr_base), 64);
        check("t5_rec_len", 32'(rec_len), 64);
        check("t5_mem63", mem[63], 32'h13F);
        check("t5_mem0", mem[0], 32'h100);

        // rec_start beats play_start; stop beats tick
        rec_start  = 1'b1;
        play_start = 1'b1;
        cyc(1);
        rec_start  = 1'b0;
        play_start = 1'b0;
        check("t6_both_state", 32'(state_out), 1);
        check("t6_ovf_clear", 32'(overflow), 0);
        check("t6_len_clear", 32'(rec_len), 0);
        wr_base = wr_cnt;
        cyc(2);
        note_in = 32'h5;
        tick    = 1'b1;
        stop    = 1'b1;
        cyc(1);
        tick    = 1'b0;
        stop    = 1'b0;
        check("t6_stop_wren", 32'(ram_wren), 0);
        check("t6_stop_state", 32'(state_out), 0);
        cyc(2);
        check("t6_stop_writes", 32'(wr_cnt - wr_base), 0);
        check("t6_stop_len", 32'(rec_len), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
